switching_merge_checker: RTL and testbench

Inverse of the DEM switching element: takes the registered output pair of one switching node (x_out1, x_out2, s_out) plus the PN bit that steered it, and rebuilds the node input and switching sequence. Compares both against the expected values and tracks mismatches in a saturating counter with a three-state fault FSM. Sits beside each tree node as a built-in self-check for DEM-DAC bring-up and regression.

---
 rtl/lib_switchblock_pkg.sv | 14 +
 rtl/switching_unmerge.sv | 26 ++
 rtl/switching_merge_checker.sv | 129 ++++++++++++
 tb/tb_switching_merge_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// Shared switch-block definitions: data width, checker state encoding and counter sizing.
package lib_switchblock_pkg;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned ERR_CNT_W   = 8;
    localparam int unsigned ERR_CNT_MAX = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FAULT = 2'd2
    } dem_chk_state_t;

endpackage

// File: rtl/switching_unmerge.sv
// Combinational inverse of one switching node: rebuilds node input and switching sequence
// from the un-swapped output pair.
module switching_unmerge
    import lib_switchblock_pkg::*;
#(
    parameter int unsigned W = WIDTH
) (
    input  logic [W-1:0] x1_i,
    input  logic [W-1:0] x2_i,
    input  logic         pn_i,
    output logic [W-1:0] x_rec_o,
    output logic [W-1:0] s_rec_o
);

    logic [W-1:0] a;
    logic [W-1:0] b;

    // Modular arithmetic undoes the node's truncating halving, wrap-around included.
    always_comb begin
        a       = pn_i ? x1_i : x2_i;
        b       = pn_i ? x2_i : x1_i;
        x_rec_o = W'(a + b);
        s_rec_o = W'({a[W-2:0], 1'b0} - x_rec_o);
    end

endmodule

// File: rtl/switching_merge_checker.sv
// Self-check beside a DEM switching node: reconstructs the node input, compares against the
// delayed reference and tracks mismatches with a saturating counter and sticky fault FSM.
module switching_merge_checker
    import lib_switchblock_pkg::*;
#(
    parameter int unsigned ERR_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     x_ref_i,
    input  logic                 pn_seq_i,
    input  logic [WIDTH-1:0]     x1_i,
    input  logic [WIDTH-1:0]     x2_i,
    input  logic [WIDTH-1:0]     s_i,
    input  logic                 clear_i,
    output logic [WIDTH-1:0]     x_rec_o,
    output logic [WIDTH-1:0]     s_rec_o,
    output logic                 rec_valid_o,
    output logic                 mismatch_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 fault_o,
    output logic [1:0]           state_o
);

    logic [WIDTH-1:0]     x_ref_q;
    logic [WIDTH-1:0]     s1_x1_q, s1_x2_q, s1_s_q, s1_ref_q;
    logic                 s1_pn_q, s1_valid_q;
    logic [WIDTH-1:0]     x_rec_q, s_rec_q;
    logic                 rec_valid_q, mismatch_q, fault_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    dem_chk_state_t       state_q;

    logic [WIDTH-1:0]     x_rec_c, s_rec_c;
    logic                 match_c;
    logic [ERR_CNT_W-1:0] cnt_inc_c;

    switching_unmerge #(.W(WIDTH)) u_unmerge (
        .x1_i    (s1_x1_q),
        .x2_i    (s1_x2_q),
        .pn_i    (s1_pn_q),
        .x_rec_o (x_rec_c),
        .s_rec_o (s_rec_c)
    );

    always_comb begin
        match_c   = (x_rec_c == s1_ref_q) && (s_rec_c == s1_s_q) && (s_rec_c[0] == x_rec_c[0]);
        cnt_inc_c = (err_cnt_q == ERR_CNT_W'(ERR_CNT_MAX)) ? err_cnt_q : ERR_CNT_W'(err_cnt_q + 1'b1);
    end

    // Reference alignment and the two data pipeline stages.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_ref_q     <= '0;
            s1_x1_q     <= '0;
            s1_x2_q     <= '0;
            s1_s_q      <= '0;
            s1_ref_q    <= '0;
            s1_pn_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            x_rec_q     <= '0;
            s_rec_q     <= '0;
            rec_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            x_ref_q    <= x_ref_i;
            s1_valid_q <= valid_i;
            if (valid_i) begin
                s1_x1_q  <= x1_i;
                s1_x2_q  <= x2_i;
                s1_s_q   <= s_i;
                s1_ref_q <= x_ref_q;
                s1_pn_q  <= pn_seq_i;
            end
            rec_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                x_rec_q <= x_rec_c;
                s_rec_q <= s_rec_c;
            end
            mismatch_q <= s1_valid_q && !match_c && !clear_i;
        end
    end

    // Error counter and fault FSM; clear takes priority over a same-cycle mismatch.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_cnt_q <= '0;
            state_q   <= IDLE;
            fault_q   <= 1'b0;
        end else if (clear_i) begin
            err_cnt_q <= '0;
            state_q   <= IDLE;
            fault_q   <= 1'b0;
        end else begin
            if (mismatch_q) begin
                err_cnt_q <= cnt_inc_c;
            end
            case (state_q)
                IDLE: begin
                    if (rec_valid_q) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (mismatch_q && (cnt_inc_c >= ERR_CNT_W'(ERR_LIMIT))) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end
                end
                FAULT: begin
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign x_rec_o     = x_rec_q;
    assign s_rec_o     = s_rec_q;
    assign rec_valid_o = rec_valid_q;
    assign mismatch_o  = mismatch_q;
    assign err_cnt_o   = err_cnt_q;
    assign fault_o     = fault_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_switching_merge_checker.sv
// Directed bench for switching_merge_checker: reconstruction, wrap-around, fault entry,
// saturation, clear priority and mid-stream reset.
module tb_switching_merge_checker;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic [15:0] x_ref_i;
    logic        pn_seq_i;
    logic [15:0] x1_i, x2_i, s_i;
    logic        clear_i;
    logic [15:0] x_rec_o, s_rec_o;
    logic        rec_valid_o, mismatch_o, fault_o;
    logic [7:0]  err_cnt_o;
    logic [1:0]  state_o;

    int checks = 0;
    int fails  = 0;

    switching_merge_checker #(.ERR_LIMIT(4)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .x_ref_i     (x_ref_i),
        .pn_seq_i    (pn_seq_i),
        .x1_i        (x1_i),
        .x2_i        (x2_i),
        .s_i         (s_i),
        .clear_i     (clear_i),
        .x_rec_o     (x_rec_o),
        .s_rec_o     (s_rec_o),
        .rec_valid_o (rec_valid_o),
        .mismatch_o  (mismatch_o),
        .err_cnt_o   (err_cnt_o),
        .fault_o     (fault_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // One isolated sample: reference at N-1, node outputs at N, results checked at N+2.
    task automatic send_one(input string name, input logic [15:0] xref, input logic pn,
                            input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] s,
                            input logic [15:0] exp_x, input logic [15:0] exp_s, input logic exp_mm);
        x_ref_i = xref; valid_i = 1'b0;
        cyc();
        valid_i = 1'b1; pn_seq_i = pn; x1_i = x1; x2_i = x2; s_i = s;
        cyc();
        valid_i = 1'b0;
        checks++;
        if (rec_valid_o !== 1'b0) begin
            fails++; $display("FAIL %s early rec_valid: got %b want 0", name, rec_valid_o);
        end
        cyc();
        checks++;
        if (x_rec_o !== exp_x) begin
            fails++; $display("FAIL %s x_rec: got %h want %h", name, x_rec_o, exp_x);
        end
        checks++;
        if (s_rec_o !== exp_s) begin
            fails++; $display("FAIL %s s_rec: got %h want %h", name, s_rec_o, exp_s);
        end
        checks++;
        if (rec_valid_o !== 1'b1) begin
            fails++; $display("FAIL %s rec_valid: got %b want 1", name, rec_valid_o);
        end
        checks++;
        if (mismatch_o !== exp_mm) begin
            fails++; $display("FAIL %s mismatch: got %b want %b", name, mismatch_o, exp_mm);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0; x_ref_i = '0;
        pn_seq_i = 1'b0; x1_i = '0; x2_i = '0; s_i = '0;
        cyc(); cyc();
        reset_i = 1'b0;
        cyc();
        checks++;
        if ({x_rec_o, s_rec_o, rec_valid_o, mismatch_o, err_cnt_o, fault_o, state_o} !== '0) begin
            fails++;
            $display("FAIL reset outputs: x=%h s=%h rv=%b mm=%b cnt=%0d f=%b st=%0d want all 0",
                     x_rec_o, s_rec_o, rec_valid_o, mismatch_o, err_cnt_o, fault_o, state_o);
        end
    endtask

    task automatic test_straight();
        send_one("straight", 16'd10, 1'b1, 16'd7, 16'd3, 16'd4, 16'd10, 16'd4, 1'b0);
        cyc();
        checks++;
        if (state_o !== 2'd1) begin
            fails++; $display("FAIL straight state: got %0d want 1", state_o);
        end
        checks++;
        if (err_cnt_o !== 8'd0) begin
            fails++; $display("FAIL straight err_cnt: got %0d want 0", err_cnt_o);
        end
    endtask

    task automatic test_swapped();
        send_one("swapped", 16'd10, 1'b0, 16'd3, 16'd7, 16'd4, 16'd10, 16'd4, 1'b0);
        send_one("odd", 16'd7, 1'b1, 16'd4, 16'd3, 16'd1, 16'd7, 16'd1, 1'b0);
    endtask

    task automatic test_wrap();
        send_one("wrap", 16'hFFFF, 1'b1, 16'h0001, 16'hFFFE, 16'h0003, 16'hFFFF, 16'h0003, 1'b0);
    endtask

    // Four back-to-back samples with x2 off by one; sample i enters at loop cycle 0..3.
    task automatic test_fault_entry();
        logic       exp_mm;
        logic [7:0] exp_cnt;
        logic       exp_f;
        x_ref_i = 16'd10; valid_i = 1'b0;
        cyc();
        for (int i = 0; i < 8; i++) begin
            exp_mm  = (i >= 2) && (i <= 5);
            exp_cnt = (i < 3) ? 8'd0 : ((i - 2 > 4) ? 8'd4 : 8'(i - 2));
            exp_f   = (i >= 6);
            checks++;
            if (mismatch_o !== exp_mm) begin
                fails++; $display("FAIL fault mismatch c%0d: got %b want %b", i, mismatch_o, exp_mm);
            end
            checks++;
            if (err_cnt_o !== exp_cnt) begin
                fails++; $display("FAIL fault err_cnt c%0d: got %0d want %0d", i, err_cnt_o, exp_cnt);
            end
            checks++;
            if (fault_o !== exp_f) begin
                fails++; $display("FAIL fault fault_o c%0d: got %b want %b", i, fault_o, exp_f);
            end
            valid_i = (i < 4); pn_seq_i = 1'b1; x1_i = 16'd7; x2_i = 16'd4; s_i = 16'd4;
            cyc();
        end
        valid_i = 1'b0;
        send_one("after_fault", 16'd10, 1'b1, 16'd7, 16'd3, 16'd4, 16'd10, 16'd4, 1'b0);
        cyc();
        checks++;
        if (state_o !== 2'd2 || fault_o !== 1'b1 || err_cnt_o !== 8'd4) begin
            fails++;
            $display("FAIL fault sticky: st=%0d f=%b cnt=%0d want st=2 f=1 cnt=4", state_o, fault_o, err_cnt_o);
        end
    endtask

    task automatic test_saturation_clear();
        x_ref_i = 16'd10; pn_seq_i = 1'b1; x1_i = 16'd7; x2_i = 16'd4; s_i = 16'd4;
        for (int i = 0; i < 300; i++) begin
            valid_i = 1'b1;
            cyc();
        end
        valid_i = 1'b0;
        repeat (4) cyc();
        checks++;
        if (err_cnt_o !== 8'd255 || state_o !== 2'd2) begin
            fails++; $display("FAIL saturate: cnt=%0d st=%0d want cnt=255 st=2", err_cnt_o, state_o);
        end
        // Corrupted sample whose mismatch_o pulse coincides with clear_i.
        cyc();
        valid_i = 1'b1;
        cyc();
        valid_i = 1'b0;
        cyc();
        checks++;
        if (mismatch_o !== 1'b1 || rec_valid_o !== 1'b1) begin
            fails++; $display("FAIL clear_pre: mm=%b rv=%b want 1 1", mismatch_o, rec_valid_o);
        end
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        checks++;
        if (err_cnt_o !== 8'd0 || state_o !== 2'd0 || fault_o !== 1'b0) begin
            fails++;
            $display("FAIL clear: cnt=%0d st=%0d f=%b want 0 0 0", err_cnt_o, state_o, fault_o);
        end
        cyc();
        checks++;
        if (err_cnt_o !== 8'd0 || state_o !== 2'd0) begin
            fails++; $display("FAIL clear_hold: cnt=%0d st=%0d want 0 0", err_cnt_o, state_o);
        end
    endtask

    task automatic test_reset_midstream();
        x_ref_i = 16'd10; valid_i = 1'b0;
        cyc();
        valid_i = 1'b1; pn_seq_i = 1'b1; x1_i = 16'd7; x2_i = 16'd4; s_i = 16'd4;
        cyc();
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if ({x_rec_o, s_rec_o, rec_valid_o, mismatch_o, err_cnt_o, fault_o, state_o} !== '0) begin
            fails++;
            $display("FAIL midreset outputs: x=%h s=%h rv=%b mm=%b cnt=%0d f=%b st=%0d want all 0",
                     x_rec_o, s_rec_o, rec_valid_o, mismatch_o, err_cnt_o, fault_o, state_o);
        end
        valid_i = 1'b0;
        cyc(); cyc();
        reset_i = 1'b0;
        repeat (3) begin
            cyc();
            checks++;
            if (mismatch_o !== 1'b0 || rec_valid_o !== 1'b0 || err_cnt_o !== 8'd0) begin
                fails++;
                $display("FAIL midreset drain: mm=%b rv=%b cnt=%0d want 0 0 0", mismatch_o, rec_valid_o, err_cnt_o);
            end
        end
        send_one("post_reset", 16'd10, 1'b1, 16'd7, 16'd3, 16'd4, 16'd10, 16'd4, 1'b0);
        cyc();
        checks++;
        if (state_o !== 2'd1 || err_cnt_o !== 8'd0) begin
            fails++; $display("FAIL post_reset state: st=%0d cnt=%0d want 1 0", state_o, err_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_swapped();
        test_wrap();
        test_fault_entry();
        test_saturation_clear();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
